// File: rtl/boot_seq_ctrl.sv
// =============================================================================
// boot_seq_ctrl
// -----------------------------------------------------------------------------
// Boot sequencer for the instruction side of the core. Program bytes arriving
// from the UART receiver are packed big-endian into 32-bit words and written
// to the instruction memory write port. The image ends with an END_MARKER word,
// which is itself written. The core is then released into EXEC. A halt request
// in EXEC returns the core to STALL, and it stays there until the next start.
//
// Configuration macro:
//   LOAD_CHECKSUM_EN - when defined, the marker is followed by one trailer
//                      word. The trailer must equal the 32-bit wrapping sum of
//                      every non-marker word written. A mismatch ends in ERR
//                      with err_checksum set. The trailer is not written to
//                      memory and is not counted in word_count.
//
// Parameters:
//   INST_SIZE   instruction memory address width in words (depth 2**INST_SIZE)
//   END_MARKER  word terminating a program image
//
// Ports:
//   clk           clock
//   rstn          synchronous active-low reset
//   start         one-cycle pulse, begins a load (honoured in IDLE and ERR)
//   rx_valid      rx_data strobe, one cycle per byte
//   rx_data       received byte
//   halt_req      stop request, sampled in EXEC only
//   mode          3'd0 STALL, 3'd1 LOAD, 3'd2 EXEC
//   wr_en         instruction memory write strobe (one cycle per word)
//   wr_addr       word address of the write
//   wr_data       word being written
//   word_count    words written in the current load, marker included
//   done          load completed; sticky until the next start
//   err_overflow  memory filled without a marker; sticky until the next start
//   err_checksum  (LOAD_CHECKSUM_EN only) trailer mismatch; sticky until start
// =============================================================================
module boot_seq_ctrl #(
    parameter int          INST_SIZE  = 15,
    parameter logic [31:0] END_MARKER = 32'h0000_003F
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic                 rx_valid,
    input  logic [7:0]           rx_data,
    input  logic                 halt_req,
    output logic [2:0]           mode,
    output logic                 wr_en,
    output logic [INST_SIZE-1:0] wr_addr,
    output logic [31:0]          wr_data,
    output logic [INST_SIZE:0]   word_count,
    output logic                 done,
    output logic                 err_overflow
`ifdef LOAD_CHECKSUM_EN
    ,
    output logic                 err_checksum
`endif
);

    // -------------------------------------------------------------------------
    // Encodings
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_EXEC = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    localparam logic [2:0] MODE_STALL = 3'd0;
    localparam logic [2:0] MODE_LOAD  = 3'd1;
    localparam logic [2:0] MODE_EXEC  = 3'd2;

    localparam logic [INST_SIZE-1:0] PTR_ONE   = {{(INST_SIZE-1){1'b0}}, 1'b1};
    localparam logic [INST_SIZE:0]   COUNT_ONE = {{INST_SIZE{1'b0}}, 1'b1};

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t               state;
    logic [1:0]           byte_cnt;   // byte position within the current word
    logic [23:0]          byte_sr;    // first three bytes of the word, oldest on top
    logic [INST_SIZE-1:0] wr_ptr;     // address the next complete word goes to

    // A terminating write is in flight (wr_en high this cycle). The state
    // changes on the following edge, and any byte seen meanwhile is dropped.
    logic                 fin_pend;   // marker written, EXEC next
    logic                 ovf_pend;   // last address filled without marker, ERR next

`ifdef LOAD_CHECKSUM_EN
    logic [31:0]          cs_sum;     // wrapping sum of written non-marker words
    logic                 cs_trailer; // marker seen, now assembling the trailer
`endif

    // -------------------------------------------------------------------------
    // Datapath helpers
    // -------------------------------------------------------------------------
    logic [31:0] rx_word;     // complete word when the 4th byte arrives
    logic        word_last;   // this byte completes a word
    logic        ptr_at_end;  // next write lands on the last memory address

    assign rx_word    = {byte_sr, rx_data};
    assign word_last  = (byte_cnt == 2'd3);
    assign ptr_at_end = &wr_ptr;

    // -------------------------------------------------------------------------
    // Sequencer
    // -------------------------------------------------------------------------
    // NOTE: the reset is synchronous, so it sits inside the clocked branch and
    // clk is the only signal in the sensitivity list. Every register is
    // cleared, including the half-built word, so an aborted load never leaks
    // bytes into the next one.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= S_IDLE;
            mode         <= MODE_STALL;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            word_count   <= '0;
            done         <= 1'b0;
            err_overflow <= 1'b0;
            byte_cnt     <= '0;
            byte_sr      <= '0;
            wr_ptr       <= '0;
            fin_pend     <= 1'b0;
            ovf_pend     <= 1'b0;
`ifdef LOAD_CHECKSUM_EN
            cs_sum       <= '0;
            cs_trailer   <= 1'b0;
            err_checksum <= 1'b0;
`endif
        end else begin
            // NOTE: every register here is assigned with <=, so all right-hand
            // sides see the values from before this edge. wr_addr therefore
            // captures wr_ptr before it is incremented on the same edge.
            wr_en <= 1'b0;

            case (state)
                // IDLE and ERR differ only in how they were reached. Both wait
                // for start and begin a fresh load with all statistics cleared.
                S_IDLE, S_ERR: begin
                    if (start) begin
                        state        <= S_LOAD;
                        mode         <= MODE_LOAD;
                        done         <= 1'b0;
                        err_overflow <= 1'b0;
                        word_count   <= '0;
                        byte_cnt     <= '0;
                        wr_ptr       <= '0;
                        fin_pend     <= 1'b0;
                        ovf_pend     <= 1'b0;
`ifdef LOAD_CHECKSUM_EN
                        cs_sum       <= '0;
                        cs_trailer   <= 1'b0;
                        err_checksum <= 1'b0;
`endif
                    end
                end

                S_LOAD: begin
                    if (fin_pend) begin
                        fin_pend <= 1'b0;
                        state    <= S_EXEC;
                        mode     <= MODE_EXEC;
                        done     <= 1'b1;
                    end else if (ovf_pend) begin
                        ovf_pend     <= 1'b0;
                        state        <= S_ERR;
                        mode         <= MODE_STALL;
                        err_overflow <= 1'b1;
                    end else if (rx_valid) begin
                        // The counter wraps from 3 to 0, so a byte arriving in
                        // a write cycle starts the next word without a gap.
                        byte_cnt <= byte_cnt + 2'd1;
                        if (!word_last) begin
                            byte_sr <= {byte_sr[15:0], rx_data};
`ifdef LOAD_CHECKSUM_EN
                        end else if (cs_trailer) begin
                            // The trailer is compared, never written.
                            cs_trailer <= 1'b0;
                            if (rx_word == cs_sum) begin
                                state <= S_EXEC;
                                mode  <= MODE_EXEC;
                                done  <= 1'b1;
                            end else begin
                                state        <= S_ERR;
                                mode         <= MODE_STALL;
                                err_checksum <= 1'b1;
                            end
`endif
                        end else begin
                            wr_en      <= 1'b1;
                            wr_addr    <= wr_ptr;
                            wr_data    <= rx_word;
                            word_count <= word_count + COUNT_ONE;
                            wr_ptr     <= wr_ptr + PTR_ONE;
                            if (rx_word == END_MARKER) begin
                                // A marker on the last address still completes
                                // normally, so the overflow check does not apply.
`ifdef LOAD_CHECKSUM_EN
                                cs_trailer <= 1'b1;
`else
                                fin_pend   <= 1'b1;
`endif
                            end else begin
`ifdef LOAD_CHECKSUM_EN
                                cs_sum <= cs_sum + rx_word;
`endif
                                if (ptr_at_end) begin
                                    ovf_pend <= 1'b1;
                                end
                            end
                        end
                    end
                end

                S_EXEC: begin
                    if (halt_req) begin
                        state <= S_IDLE;
                        mode  <= MODE_STALL;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    mode  <= MODE_STALL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_boot_seq_ctrl.sv
// =============================================================================
// tb_boot_seq_ctrl
// -----------------------------------------------------------------------------
// Self-checking bench for boot_seq_ctrl with a 4-word memory (INST_SIZE=2).
// Each load is described as a list of program words. A reference model walks
// that list using the load rules: write address i gets word i; the load stops
// at the marker or when the last address is filled. The model then predicts
// the write sequence, final mode, sticky flags and word count. A monitor
// records the writes the DUT actually produces so the two can be compared.
// Define LOAD_CHECKSUM_EN to build the bench and the DUT with the trailer check.
// =============================================================================
`timescale 1ns/1ps
module tb_boot_seq_ctrl;

    localparam int          N     = 2;
    localparam int          DEPTH = 1 << N;
    localparam logic [31:0] MARK  = 32'h0000_003F;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           start = 1'b0;
    logic           rx_valid = 1'b0;
    logic [7:0]     rx_data = 8'h00;
    logic           halt_req = 1'b0;
    logic [2:0]     mode;
    logic           wr_en;
    logic [N-1:0]   wr_addr;
    logic [31:0]    wr_data;
    logic [N:0]     word_count;
    logic           done;
    logic           err_overflow;
`ifdef LOAD_CHECKSUM_EN
    logic           err_checksum;
`endif

    boot_seq_ctrl #(.INST_SIZE(N), .END_MARKER(MARK)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .halt_req     (halt_req),
        .mode         (mode),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .word_count   (word_count),
        .done         (done),
        .err_overflow (err_overflow)
`ifdef LOAD_CHECKSUM_EN
        ,
        .err_checksum (err_checksum)
`endif
    );

    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Checking
    // -------------------------------------------------------------------------
    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Monitor: write log and the cycle on which LOAD is left
    // -------------------------------------------------------------------------
    int          cyc = 0;
    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    int          last_wr_cyc = 0;
    int          exit_cyc = -1;
    logic [2:0]  prev_mode = 3'd0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            obs_addr.push_back(32'(wr_addr));
            obs_data.push_back(wr_data);
            last_wr_cyc = cyc;
        end
        if (prev_mode == 3'd1 && mode != 3'd1 && exit_cyc < 0) exit_cyc = cyc;
        prev_mode = mode;
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 ns after the rising edge)
    // -------------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        step();
        rx_valid = 1'b0;
    endtask

    // Big-endian, with an optional random idle gap before each byte.
    task automatic send_word(input logic [31:0] w, input int gap_max);
        for (int k = 3; k >= 0; k--) begin
            repeat ($urandom_range(0, gap_max)) step();
            send_byte(w[8*k +: 8]);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_halt();
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        check("halt_mode", 32'(mode), 32'd0);
        check("halt_done_sticky", 32'(done), 32'd1);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 3) == 0) w = 32'($urandom_range(0, 255));
        if (w == MARK) w = MARK + 32'd1;
        return w;
    endfunction

    // -------------------------------------------------------------------------
    // One load: drive plan_q, predict the outcome, compare
    // -------------------------------------------------------------------------
    logic [31:0] plan_q[$];
    bit          model_exec = 1'b0;

    task automatic run_load(input int gap_max, input bit bad_sum, input bit extra);
        logic [31:0] exp_a[$];
        logic [31:0] exp_d[$];
        logic [31:0] sum;
        logic [31:0] w;
        logic [31:0] exp_mode;
        bit          marked;
        bit          ovf;
        bit          cs_fail;
        int          n;
        sum = 32'd0; marked = 1'b0; ovf = 1'b0; cs_fail = 1'b0; n = 0;

        obs_addr.delete();
        obs_data.delete();
        pulse_start();
        check("start_mode", 32'(mode), 32'd1);
        check("start_done_clr", 32'(done), 32'd0);
        check("start_ovf_clr", 32'(err_overflow), 32'd0);
        check("start_count_clr", 32'(word_count), 32'd0);
        exit_cyc = -1;

        for (int i = 0; i < plan_q.size(); i++) begin
            w = plan_q[i];
            exp_a.push_back(32'(i));
            exp_d.push_back(w);
            n++;
            send_word(w, gap_max);
            if (w == MARK) begin
                marked = 1'b1;
                break;
            end
            sum += w;
            if (i == DEPTH - 1) begin
                ovf = 1'b1;
                break;
            end
        end

`ifdef LOAD_CHECKSUM_EN
        if (marked) begin
            send_word(sum + (bad_sum ? 32'd1 : 32'd0), gap_max);
            cs_fail = bad_sum;
        end
`else
        // Bytes arriving in the marker's write cycle and after are dropped.
        if (extra) for (int k = 0; k < 4; k++) send_byte(8'($urandom));
`endif
        repeat (4) step();

        exp_mode = (marked && !cs_fail) ? 32'd2 : (marked || ovf) ? 32'd0 : 32'd1;
        check("n_writes", 32'(obs_addr.size()), 32'(exp_a.size()));
        for (int i = 0; i < exp_a.size() && i < obs_addr.size(); i++) begin
            check("wr_addr", obs_addr[i], exp_a[i]);
            check("wr_data", obs_data[i], exp_d[i]);
        end
        check("end_mode", 32'(mode), exp_mode);
        check("end_done", 32'(done), 32'(marked && !cs_fail));
        check("end_ovf", 32'(err_overflow), 32'(ovf));
        check("end_count", 32'(word_count), 32'(n));
`ifdef LOAD_CHECKSUM_EN
        check("end_cs_err", 32'(err_checksum), 32'(cs_fail));
        if (ovf) check("exit_latency", 32'(exit_cyc - last_wr_cyc), 32'd1);
`else
        if (marked || ovf) check("exit_latency", 32'(exit_cyc - last_wr_cyc), 32'd1);
`endif
        model_exec = (exp_mode == 32'd2);
    endtask

    // -------------------------------------------------------------------------
    // Main sequence
    // -------------------------------------------------------------------------
    initial begin
        repeat (3) step();
        check("rst_mode", 32'(mode), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_count", 32'(word_count), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rstn = 1'b1;
        step();

        // Two-word image.
        plan_q = '{32'h1234_5678, MARK};
        run_load(1, 1'b0, 1'b0);

        // EXEC ignores start and bytes.
        obs_addr.delete();
        pulse_start();
        for (int k = 0; k < 4; k++) send_byte(8'($urandom));
        repeat (2) step();
        check("exec_no_write", 32'(obs_addr.size()), 32'd0);
        check("exec_mode_hold", 32'(mode), 32'd2);
        do_halt();

        // Back-to-back bytes, marker on the last address, trailing bytes.
        plan_q = '{32'hDEAD_BEEF, 32'h0102_0304, 32'hCAFE_F00D, MARK};
        run_load(0, 1'b0, 1'b1);
        do_halt();

        // Reset in the middle of a word.
        pulse_start();
        send_byte(8'h11);
        send_byte(8'h22);
        rstn = 1'b0;
        step();
        check("midrst_mode", 32'(mode), 32'd0);
        check("midrst_wr_en", 32'(wr_en), 32'd0);
        check("midrst_wr_addr", 32'(wr_addr), 32'd0);
        check("midrst_wr_data", wr_data, 32'd0);
        check("midrst_count", 32'(word_count), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_ovf", 32'(err_overflow), 32'd0);
        rstn = 1'b1;
        step();
        plan_q = '{32'hAABB_CCDD, MARK};
        run_load(1, 1'b0, 1'b0);
        do_halt();

        // Overflow, then a recovery load started from ERR.
        plan_q = '{32'h1, 32'h2, 32'h3, 32'h4};
        run_load(0, 1'b0, 1'b1);
        plan_q = '{32'h5, 32'h6, 32'h7, MARK};
        run_load(1, 1'b0, 1'b0);
        do_halt();

`ifdef LOAD_CHECKSUM_EN
        plan_q = '{32'h1, 32'h2, MARK};
        run_load(1, 1'b0, 1'b0);
        do_halt();
        run_load(1, 1'b1, 1'b0);
`endif

        // Randomised loads.
        for (int t = 0; t < 25; t++) begin
            int nd;
            if (model_exec) do_halt();
            nd = $urandom_range(0, DEPTH + 1);
            plan_q.delete();
            for (int i = 0; i < nd; i++) plan_q.push_back(rand_word());
            plan_q.push_back(MARK);
            run_load($urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
